// File: rtl/equiv_sweep_ctrl_pkg.sv
// Shared types and defaults for the equivalence sweep controller.
//   state_t    : sweep sequencer state encoding
//   N_IN_DEF   : default function input width
//   SETTLE_DEF : default settle delay in idle cycles
//   cnt_width  : bits needed to hold a value 0..max_val (minimum 1)
package equiv_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned N_IN_DEF   = 2;
    localparam int unsigned SETTLE_DEF = 1;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/equiv_sweep_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag; holds the settle delay between
// driving a vector and comparing the two function outputs.
//   i_clk  : rising-edge clock
//   i_rst  : synchronous active-high reset (count -> 0)
//   i_load : load the count with SETTLE
//   i_dec  : decrement by one, saturating at zero
//   o_zero : count is zero
module settle_timer
    import equiv_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int unsigned CW = cnt_width(SETTLE);

    logic [CW-1:0] r_cnt;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(SETTLE);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// Sweeps every N_IN-bit input vector through two implementations of the same
// Boolean function, compares their outputs after SETTLE idle cycles and
// reports the mismatch count, first failing vector and pass/fail.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a sweep (IDLE only) / cancel a sweep in progress
//   a_in, b_in      : outputs of implementations A and B
//   x_out           : registered test vector driven to both implementations
//   busy            : sweep in progress (WAIT or CHECK)
//   done            : one-cycle pulse on sweep completion
//   pass            : last completed sweep had no mismatches
//   mismatch_cnt    : mismatching vectors in the current/last sweep
//   fail_valid      : at least one mismatch recorded
//   first_fail_vec  : first vector that mismatched
module equiv_sweep_ctrl
    import equiv_sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            a_in,
    input  logic            b_in,
    output logic [N_IN-1:0] x_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    state_t r_state;

    logic w_zero;
    logic w_load;
    logic w_dec;
    logic w_last;
    logic w_diff;

    assign w_last = &x_out;
    assign w_diff = a_in ^ b_in;

    // Reload the settle delay whenever a new vector is driven.
    assign w_load = ((r_state == ST_IDLE) && start) ||
                    ((r_state == ST_CHECK) && !abort && !w_last);
    assign w_dec  = (r_state == ST_WAIT) && !abort;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    // Sweep sequencer with registered outputs; abort beats any CHECK update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            x_out          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        x_out          <= '0;
                        mismatch_cnt   <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        r_state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_zero) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_diff) begin
                            mismatch_cnt <= mismatch_cnt + (N_IN + 1)'(1);
                            if (!fail_valid) begin
                                first_fail_vec <= x_out;
                                fail_valid     <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            x_out   <= x_out + N_IN'(1);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    // mismatch_cnt already includes the final CHECK here.
                    pass    <= (mismatch_cnt == '0);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Randomized scoreboard bench for equiv_sweep_ctrl. Three instances:
//   u0: N_IN=2 SETTLE=1, u1: N_IN=3 SETTLE=3, u2: N_IN=2 SETTLE=0.
// Each instance's B output is A XOR a per-vector fault mask chosen by the bench.
module tb_equiv_sweep_ctrl;

    typedef struct {
        int which;
        int cnt;
        int fv;
        int ff;
        int pass;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [2:0] abort_v = 3'b000;
    logic [7:0] mask_v [3];

    int n_vec = 0;
    int n_err = 0;
    exp_t q[$];

    // DUT-side nets
    logic [1:0] xa, ffa;
    logic [2:0] cnta;
    logic       a_a, b_a, busy_a, done_a, pass_a, fv_a;
    logic [2:0] xb, ffb;
    logic [3:0] cntb;
    logic       a_b, b_b, busy_b, done_b, pass_b, fv_b;
    logic [1:0] xc, ffc;
    logic [2:0] cntc;
    logic       a_c, b_c, busy_c, done_c, pass_c, fv_c;

    // f5a/f5b style: s = ~(a & ~b), a = x[1], b = x[0]
    assign a_a = ~(xa[1] & ~xa[0]);
    assign b_a = ~(xa[1] & ~xa[0]) ^ mask_v[0][3'(xa)];
    assign a_b = ^xb;
    assign b_b = (^xb) ^ mask_v[1][xb];
    assign a_c = xc[0] | xc[1];
    assign b_c = (xc[0] | xc[1]) ^ mask_v[2][3'(xc)];

    equiv_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .a_in(a_a), .b_in(b_a), .x_out(xa), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_cnt(cnta), .fail_valid(fv_a), .first_fail_vec(ffa));

    equiv_sweep_ctrl #(.N_IN(3), .SETTLE(3)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .a_in(a_b), .b_in(b_b), .x_out(xb), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_cnt(cntb), .fail_valid(fv_b), .first_fail_vec(ffb));

    equiv_sweep_ctrl #(.N_IN(2), .SETTLE(0)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
        .a_in(a_c), .b_in(b_c), .x_out(xc), .busy(busy_c), .done(done_c),
        .pass(pass_c), .mismatch_cnt(cntc), .fail_valid(fv_c), .first_fail_vec(ffc));

    // Uniform views of the three instances
    int x_v [3], cnt_v [3], ff_v [3];
    logic [2:0] busy_v, done_v, pass_v, fv_v;
    always_comb begin
        x_v[0] = int'(xa);   x_v[1] = int'(xb);   x_v[2] = int'(xc);
        cnt_v[0] = int'(cnta); cnt_v[1] = int'(cntb); cnt_v[2] = int'(cntc);
        ff_v[0] = int'(ffa); ff_v[1] = int'(ffb); ff_v[2] = int'(ffc);
        busy_v = {busy_c, busy_b, busy_a};
        done_v = {done_c, done_b, done_a};
        pass_v = {pass_c, pass_b, pass_a};
        fv_v   = {fv_c, fv_b, fv_a};
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int nvec_of(input int w);
        return (w == 1) ? 8 : 4;
    endfunction

    function automatic int settle_of(input int w);
        return (w == 0) ? 1 : ((w == 1) ? 3 : 0);
    endfunction

    // Run one full sweep on instance w; optional stray start while busy/DONE
    // and optional abort held together with start (both must be ignored).
    task automatic run(input int w, input logic [7:0] m, input bit poke, input bit abort_hi);
        exp_t e;
        int nv, per, k;
        nv  = nvec_of(w);
        per = settle_of(w) + 2;
        mask_v[w] = m;
        e.which = w; e.cnt = 0; e.fv = 0; e.ff = 0;
        for (int v = 0; v < nv; v++) begin
            if (m[v]) begin
                if (e.fv == 0) e.ff = v;
                e.fv = 1;
                e.cnt++;
            end
        end
        e.pass = (e.cnt == 0) ? 1 : 0;
        e.done_cyc = cyc + nv * per + 1;
        q.push_back(e);
        start_v[w] = 1'b1;
        if (abort_hi) abort_v[w] = 1'b1;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
        abort_v[w] = 1'b0;
        chk($sformatf("u%0d_busy_first", w), int'(busy_v[w]), 1);
        chk($sformatf("u%0d_x_first", w), x_v[w], 0);
        k = $urandom_range(0, nv * per);
        for (int i = 0; i < nv * per + 2; i++) begin
            if (poke && i == k) start_v[w] = 1'b1;
            @(posedge clk); #1;
            start_v[w] = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops an expectation on each done pulse.
    initial begin
        bit   pend;
        int   pw, pexp;
        exp_t e;
        pend = 0; pw = 0; pexp = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk($sformatf("u%0d_pass", pw), int'(pass_v[pw]), pexp);
                pend = 0;
            end
            for (int w = 0; w < 3; w++) begin
                if (done_v[w] === 1'b1) begin
                    if (q.size() == 0 || q[0].which != w) begin
                        chk($sformatf("u%0d_unexpected_done", w), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("u%0d_done_cycle", w), cyc, e.done_cyc);
                        chk($sformatf("u%0d_mismatch_cnt", w), cnt_v[w], e.cnt);
                        chk($sformatf("u%0d_fail_valid", w), int'(fv_v[w]), e.fv);
                        chk($sformatf("u%0d_first_fail_vec", w), ff_v[w], e.ff);
                        pend = 1; pw = w; pexp = e.pass;
                    end
                end
            end
            if (q.size() > 0 && cyc > q[0].done_cyc) begin
                chk($sformatf("u%0d_done_timeout", q[0].which), 0, 1);
                void'(q.pop_front());
            end
        end
    end

    // u1: every vector must be held exactly SETTLE+2 = 5 busy cycles, stepping by one.
    initial begin
        bit was_busy;
        int prev, runlen;
        was_busy = 0; prev = 0; runlen = 0;
        forever begin
            @(negedge clk);
            if (busy_b === 1'b1) begin
                if (!was_busy) begin
                    prev = x_v[1];
                    runlen = 1;
                end else if (x_v[1] != prev) begin
                    chk("u1_x_hold", runlen, 5);
                    chk("u1_x_step", x_v[1], prev + 1);
                    prev = x_v[1];
                    runlen = 1;
                end else begin
                    runlen++;
                end
            end else if (was_busy && rst == 1'b0) begin
                chk("u1_x_hold_last", runlen, 5);
            end
            was_busy = (busy_b === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk_zero(input int w, input string tag);
        chk($sformatf("u%0d_%s_x", w, tag), x_v[w], 0);
        chk($sformatf("u%0d_%s_busy", w, tag), int'(busy_v[w]), 0);
        chk($sformatf("u%0d_%s_done", w, tag), int'(done_v[w]), 0);
        chk($sformatf("u%0d_%s_pass", w, tag), int'(pass_v[w]), 0);
        chk($sformatf("u%0d_%s_cnt", w, tag), cnt_v[w], 0);
        chk($sformatf("u%0d_%s_fv", w, tag), int'(fv_v[w]), 0);
        chk($sformatf("u%0d_%s_ff", w, tag), ff_v[w], 0);
    endtask

    initial begin
        for (int w = 0; w < 3; w++) mask_v[w] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) chk_zero(w, "reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // u0 directed: clean, single fault at 10, all failing
        run(0, 8'h00, 0, 0);
        run(0, 8'h04, 0, 0);
        run(0, 8'h0F, 1, 0);
        run(0, 8'h00, 1, 1);
        // u0 randomized
        for (int i = 0; i < 12; i++) begin
            run(0, 8'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
        end

        // Abort in CHECK of vector 01 with mismatches on 00 and 01
        run(0, 8'h00, 0, 0);
        mask_v[0] = 8'h03;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("u0_abort_pre_x", x_v[0], 1);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        chk("u0_abort_busy", int'(busy_v[0]), 0);
        chk("u0_abort_cnt", cnt_v[0], 1);
        chk("u0_abort_fv", int'(fv_v[0]), 1);
        chk("u0_abort_ff", ff_v[0], 0);
        chk("u0_abort_pass", int'(pass_v[0]), 0);
        chk("u0_abort_x", x_v[0], 1);
        repeat (16) @(posedge clk);
        #1;
        chk("u0_abort_idle_busy", int'(busy_v[0]), 0);

        // Reset mid-WAIT after a passing sweep
        run(0, 8'h00, 0, 0);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero(0, "midrst");
        run(0, 8'h02, 0, 0);

        // u1: N_IN=3, SETTLE=3
        run(1, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) run(1, 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 0);
        run(1, 8'hFF, 0, 0);

        // u2: SETTLE=0, every vector failing first, then random
        run(2, 8'h0F, 0, 0);
        for (int i = 0; i < 4; i++) run(2, 8'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), 0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
